// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants for the memory port arbiter
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 80;
  localparam int NREQ_MIN   = 2;
  localparam int NREQ_MAX   = 4;

  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - round-robin arbiter, one-hot grant, pointer follows last winner
module rr_arb
  import mem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW  = ptr_w(N);
  localparam int PW1 = PW + 1;
  localparam logic [PW:0] NV = PW1'(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] off;
  logic [PW-1:0] win;
  logic [PW-1:0] nxt;
  logic [N-1:0]  rot;
  logic [PW:0]   sum;
  logic [PW:0]   inc;

  // Rotate requests so the pointer position sits at bit 0, then take the first set bit.
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = PW'(k);
    end
    sum   = {1'b0, ptr} + {1'b0, off};
    win   = (sum >= NV) ? PW'(sum - NV) : sum[PW-1:0];
    inc   = {1'b0, win} + PW1'(1);
    nxt   = (inc == NV) ? '0 : inc[PW-1:0];
    grant = (|req) ? (N'(1) << win) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (|req) begin
      ptr <= nxt;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - arbitrates N requesters onto one async-read / sync-write memory
// Independent round-robin on read and write ports; read data registered with write forwarding.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic [ADDR_W-1:0]      mem_raddr,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   mem_wen,
  output logic [ADDR_W-1:0]      mem_waddr,
  output logic [DATA_W-1:0]      mem_wdata
);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("mem_arb: NREQ out of range");
  end

  logic [NREQ-1:0]   rd_req;
  logic [NREQ-1:0]   wr_req;
  logic [NREQ-1:0]   rd_gnt;
  logic [NREQ-1:0]   wr_gnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] held_raddr;
  logic              rd_any;
  logic              wr_any;
  logic              fwd;

  // Gating with rst_n keeps ready and mem_wen low for the whole reset pulse.
  assign rd_req = req_valid & ~req_we & {NREQ{rst_n}};
  assign wr_req = req_valid &  req_we & {NREQ{rst_n}};

  rr_arb #(.N(NREQ)) u_rd_arb (.clk(clk), .rst_n(rst_n), .req(rd_req), .grant(rd_gnt));
  rr_arb #(.N(NREQ)) u_wr_arb (.clk(clk), .rst_n(rst_n), .req(wr_req), .grant(wr_gnt));

  always_comb begin
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rd_gnt[i]) rd_addr = rd_addr | req_addr[i*ADDR_W +: ADDR_W];
      if (wr_gnt[i]) begin
        wr_addr = wr_addr | req_addr[i*ADDR_W +: ADDR_W];
        wr_data = wr_data | req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_any    = |rd_gnt;
  assign wr_any    = |wr_gnt;
  assign req_ready = rd_gnt | wr_gnt;
  assign mem_wen   = wr_any;
  assign mem_waddr = wr_addr;
  assign mem_wdata = wr_data;
  assign mem_raddr = rd_any ? rd_addr : held_raddr;
  // The memory only commits the write at the edge, so a same-address read must take the new data here.
  assign fwd       = rd_any & wr_any & (wr_addr == rd_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_raddr <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= rd_gnt;
      if (rd_any) begin
        held_raddr <= rd_addr;
        resp_rdata <= fwd ? wr_data : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb with a read-response scoreboard
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_we, req_ready, resp_valid;
  logic [11:0] req_addr;
  logic [159:0] req_wdata;
  logic [79:0] resp_rdata, mem_rdata, mem_wdata;
  logic [5:0]  mem_raddr, mem_waddr;
  logic        mem_wen;

  logic [3:0]   req_valid4, req_we4, req_ready4, resp_valid4;
  logic [23:0]  req_addr4;
  logic [319:0] req_wdata4;
  logic [79:0]  resp_rdata4, mem_rdata4, mem_wdata4;
  logic [5:0]   mem_raddr4, mem_waddr4;
  logic         mem_wen4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arb #(.NREQ(2), .ADDR_W(6), .DATA_W(80)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata));

  mem_arb #(.NREQ(4), .ADDR_W(6), .DATA_W(80)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_we(req_we4), .req_addr(req_addr4),
    .req_wdata(req_wdata4), .req_ready(req_ready4), .resp_valid(resp_valid4), .resp_rdata(resp_rdata4),
    .mem_raddr(mem_raddr4), .mem_rdata(mem_rdata4), .mem_wen(mem_wen4), .mem_waddr(mem_waddr4),
    .mem_wdata(mem_wdata4));

  assign mem_rdata4 = '0;

  function automatic logic [79:0] pat(input logic [5:0] a);
    return 80'hC3A5_5A5A_0F0F_F0F0_0000 | {74'b0, a};
  endfunction

  // Memory model: unwritten words read back an address-derived pattern.
  logic [79:0] mem    [64];
  logic        mem_wr [64] = '{default: 1'b0};
  always @(posedge clk) if (mem_wen) begin
    mem[mem_waddr]    <= mem_wdata;
    mem_wr[mem_waddr] <= 1'b1;
  end
  assign mem_rdata = mem_wr[mem_raddr] ? mem[mem_raddr] : pat(mem_raddr);

  typedef struct packed { logic [1:0] oh; logic [79:0] data; } exp_t;
  exp_t        q[$];
  logic [79:0] sh    [64];
  logic        sh_wr [64] = '{default: 1'b0};

  always @(negedge clk) begin : scoreboard
    exp_t        e;
    logic [5:0]  a;
    logic [79:0] d;
    if (!rst_n) begin
      q.delete();
      checks++;
      if (resp_valid !== 2'b00) begin errors++; $display("FAIL sb_reset_resp got=%b exp=00", resp_valid); end
    end else begin
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (resp_valid !== e.oh || resp_rdata !== e.data) begin
          errors++;
          $display("FAIL sb_resp got=%b/%h exp=%b/%h", resp_valid, resp_rdata, e.oh, e.data);
        end
      end else begin
        checks++;
        if (resp_valid !== 2'b00) begin errors++; $display("FAIL sb_spurious_resp got=%b exp=00", resp_valid); end
      end
      for (int i = 0; i < 2; i++) if (req_valid[i] && req_ready[i] && !req_we[i]) begin
        a = req_addr[i*6 +: 6];
        d = sh_wr[a] ? sh[a] : pat(a);
        for (int j = 0; j < 2; j++)
          if (req_valid[j] && req_ready[j] && req_we[j] && req_addr[j*6 +: 6] == a) d = req_wdata[j*80 +: 80];
        e.oh = 2'b00; e.oh[i] = 1'b1; e.data = d;
        q.push_back(e);
      end
      for (int j = 0; j < 2; j++) if (req_valid[j] && req_ready[j] && req_we[j]) begin
        sh[req_addr[j*6 +: 6]]    = req_wdata[j*80 +: 80];
        sh_wr[req_addr[j*6 +: 6]] = 1'b1;
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic we, input logic [5:0] a, input logic [79:0] d);
    req_valid[i] = v;
    req_we[i] = we;
    req_addr[i*6 +: 6] = a;
    req_wdata[i*80 +: 80] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_req(0, 1'b1, 1'b1, 6'd3, 80'h77);
    set_req(1, 1'b1, 1'b0, 6'd4, 80'h0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b exp=0", mem_wen); end
    checks++; if (resp_rdata !== 80'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    checks++; if (mem_raddr !== 6'd0) begin errors++; $display("FAIL reset_raddr got=%0d exp=0", mem_raddr); end
    idle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    set_req(0, 1'b1, 1'b1, 6'd5, 80'h1234);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_ready got=%b exp=01", req_ready); end
    checks++; if (mem_wen !== 1'b1 || mem_waddr !== 6'd5 || mem_wdata !== 80'h1234) begin
      errors++; $display("FAIL wr_port got=%b/%0d/%h exp=1/5/1234", mem_wen, mem_waddr, mem_wdata); end
    next_cycle();
    set_req(0, 1'b1, 1'b0, 6'd5, 80'h0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01 || mem_raddr !== 6'd5 || mem_wen !== 1'b0) begin
      errors++; $display("FAIL rd_grant got=%b/%0d/%b exp=01/5/0", req_ready, mem_raddr, mem_wen); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (resp_valid !== 2'b01 || resp_rdata !== 80'h1234) begin
      errors++; $display("FAIL rd_resp got=%b/%h exp=01/1234", resp_valid, resp_rdata); end
    next_cycle();
    @(negedge clk);
    checks++; if (resp_valid !== 2'b00 || resp_rdata !== 80'h1234) begin
      errors++; $display("FAIL rdata_hold got=%b/%h exp=00/1234", resp_valid, resp_rdata); end
    checks++; if (mem_raddr !== 6'd5 || req_ready !== 2'b00) begin
      errors++; $display("FAIL raddr_hold got=%0d/%b exp=5/00", mem_raddr, req_ready); end
    next_cycle();
  endtask

  task automatic test_rr_reads();
    int cnt[2] = '{0, 0};
    logic [1:0] exp;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 1'b0, 6'(32 + cnt[0]), 80'h0);
      set_req(1, 1'b1, 1'b0, 6'(48 + cnt[1]), 80'h0);
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++; if (req_ready !== exp) begin errors++; $display("FAIL rr_read_%0d got=%b exp=%b", k, req_ready, exp); end
      cnt[k % 2]++;
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_forward();
    set_req(0, 1'b1, 1'b1, 6'd9, 80'hAA);
    set_req(1, 1'b1, 1'b0, 6'd9, 80'h0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b11 || mem_wen !== 1'b1 || mem_raddr !== 6'd9) begin
      errors++; $display("FAIL fwd_grant got=%b/%b/%0d exp=11/1/9", req_ready, mem_wen, mem_raddr); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (resp_valid !== 2'b10 || resp_rdata !== 80'hAA) begin
      errors++; $display("FAIL fwd_resp got=%b/%h exp=10/aa", resp_valid, resp_rdata); end
    next_cycle();
  endtask

  task automatic test_parallel();
    set_req(0, 1'b1, 1'b0, 6'd20, 80'h0);
    set_req(1, 1'b1, 1'b1, 6'd30, 80'hBEEF_0001);
    @(negedge clk);
    checks++; if (req_ready !== 2'b11) begin errors++; $display("FAIL par_ready got=%b exp=11", req_ready); end
    checks++; if (mem_raddr !== 6'd20 || mem_waddr !== 6'd30 || mem_wdata !== 80'hBEEF_0001) begin
      errors++; $display("FAIL par_ports got=%0d/%0d/%h exp=20/30/beef0001", mem_raddr, mem_waddr, mem_wdata); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (resp_valid !== 2'b01 || resp_rdata !== pat(6'd20)) begin
      errors++; $display("FAIL par_resp got=%b/%h exp=01/%h", resp_valid, resp_rdata, pat(6'd20)); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 1'b0, 6'(40 + k), 80'h0);
      @(negedge clk);
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL b2b_%0d got=%b exp=01", k, req_ready); end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b1, 1'b1, 6'd51, 80'h5151);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_pre_wr got=%b exp=01", req_ready); end
    next_cycle();
    set_req(0, 1'b1, 1'b0, 6'd50, 80'h0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_pre_rd got=%b exp=01", req_ready); end
    next_cycle();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL mid_in_reset got=%b exp=00", resp_valid); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL mid_after_release got=%b exp=00", resp_valid); end
    next_cycle();
    set_req(0, 1'b1, 1'b0, 6'd52, 80'h0);
    set_req(1, 1'b1, 1'b0, 6'd53, 80'h0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_rd_ptr got=%b exp=01", req_ready); end
    next_cycle();
    req_valid[0] = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL mid_rd_second got=%b exp=10", req_ready); end
    next_cycle();
    set_req(0, 1'b1, 1'b1, 6'd54, 80'h5454);
    set_req(1, 1'b1, 1'b1, 6'd55, 80'h5555);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01 || mem_waddr !== 6'd54) begin
      errors++; $display("FAIL mid_wr_ptr got=%b/%0d exp=01/54", req_ready, mem_waddr); end
    next_cycle();
    req_valid[0] = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10 || mem_waddr !== 6'd55) begin
      errors++; $display("FAIL mid_wr_second got=%b/%0d exp=10/55", req_ready, mem_waddr); end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_starve4();
    int cnt[4] = '{0, 0, 0, 0};
    int g;
    logic [3:0] exp;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        req_valid4[i] = 1'b1;
        req_we4[i] = 1'b1;
        req_addr4[i*6 +: 6] = 6'(i * 8 + cnt[i]);
        req_wdata4[i*80 +: 80] = {16'(i + 1), 64'(cnt[i] + 100)};
      end
      g = k % 4;
      exp = 4'b0001 << g;
      @(negedge clk);
      checks++; if (req_ready4 !== exp || mem_wen4 !== 1'b1) begin
        errors++; $display("FAIL rr4_grant_%0d got=%b/%b exp=%b/1", k, req_ready4, mem_wen4, exp); end
      checks++; if (mem_waddr4 !== 6'(g * 8 + cnt[g]) || mem_wdata4 !== {16'(g + 1), 64'(cnt[g] + 100)}) begin
        errors++; $display("FAIL rr4_data_%0d got=%0d/%h exp=%0d/%h", k, mem_waddr4, mem_wdata4,
                           g * 8 + cnt[g], {16'(g + 1), 64'(cnt[g] + 100)}); end
      cnt[g]++;
      next_cycle();
    end
    req_valid4 = '0;
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    req_valid4 = '0; req_we4 = '0; req_addr4 = '0; req_wdata4 = '0;
    #2 rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_rr_reads();
    test_forward();
    test_parallel();
    test_back_to_back();
    test_reset_mid();
    test_starve4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
